// File: rtl/core_pkg.sv
// Shared fetch-stage definitions: FSM encoding, the NOP used as the reset instruction, default reset PC.
package core_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } if_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// 32-bit program counter register with synchronous active-high reset and load enable.
// Single-cycle update on load_i; holds its value otherwise.
module pc_reg #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) pc_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_VAL;
    else     pc_q <= pc_d;
  end

  assign q_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: one outstanding imem request, FETCH->HOLD takes 1 cycle plus the gnt-to-rvalid delay; the word waits in HOLD until decode retires it.
// Define IF_MISALIGN_TRAP_EN to halt with misalign_o on a misaligned next PC; otherwise the low PC bits are cleared.
module if_stage #(
  parameter logic [31:0] RESET_PC = core_pkg::DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_seq_i,
  input  logic [31:0] pc_jump_i,
  input  logic        jump_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_add4_o,
  output logic        misalign_o
);
  import core_pkg::*;

  if_state_e   state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        misalign_q, misalign_d;
  logic        pc_load;
  logic [31:0] pc_sel;
  logic [31:0] pc_next;
  logic        pc_bad;

  assign pc_sel = jump_i ? pc_jump_i : pc_seq_i;

`ifdef IF_MISALIGN_TRAP_EN
  assign pc_bad  = |pc_sel[1:0];
  assign pc_next = pc_sel;
`else
  assign pc_bad  = 1'b0;
  assign pc_next = pc_sel & ~32'h0000_0003;
`endif

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    misalign_d    = misalign_q;
    pc_load       = 1'b0;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_gnt_i) state_d = S_WAIT;
      end
      // rvalid is only meaningful here, so a same-cycle-as-gnt rvalid is never taken
      S_WAIT: begin
        if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        instr_valid_o = 1'b1;
        if (instr_ready_i) begin
          if (pc_bad) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            pc_load = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      instr_q    <= NOP_INSTR;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
    end
  end

  pc_reg #(
    .RESET_VAL(RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (pc_load),
    .d_i    (pc_next),
    .q_o    (pc_o)
  );

  assign imem_addr_o = pc_o;
  assign pc_add4_o   = pc_o + 32'd4;
  assign instr_o     = instr_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: transaction-level reference of expected PC and held instruction.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_seq_i, pc_jump_i;
  logic        jump_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] pc_o, pc_add4_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;
  logic        exp_halt;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_seq_i      (pc_seq_i),
    .pc_jump_i     (pc_jump_i),
    .jump_i        (jump_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .pc_o          (pc_o),
    .pc_add4_o     (pc_add4_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random values on inputs the DUT must ignore in the current phase.
  task automatic noise(input bit gnt_ok, input bit rv_ok, input bit rdy_ok);
    imem_gnt_i    = gnt_ok ? 1'($urandom_range(0, 1)) : 1'b0;
    imem_rvalid_i = rv_ok  ? 1'($urandom_range(0, 1)) : 1'b0;
    instr_ready_i = rdy_ok ? 1'($urandom_range(0, 1)) : 1'b0;
    imem_rdata_i  = $urandom;
    jump_i        = 1'($urandom_range(0, 1));
    pc_seq_i      = $urandom;
    pc_jump_i     = $urandom;
  endtask

  // Next PC as seen by the architecture: target chosen at retire, trap or low-bit clearing by build.
  task automatic model_retire(input logic j, input logic [31:0] seq, input logic [31:0] jmp);
    logic [31:0] tgt;
    tgt = j ? jmp : seq;
`ifdef IF_MISALIGN_TRAP_EN
    if (tgt % 4 != 0) exp_halt = 1'b1;
    else              exp_pc   = tgt;
`else
    exp_pc = tgt - (tgt % 4);
`endif
  endtask

  // One full fetch/retire transaction with the given delays, checked every cycle.
  task automatic run_txn(input int gnt_dly, input int rv_dly, input logic [31:0] data,
                         input int rdy_dly, input logic j, input logic [31:0] seq,
                         input logic [31:0] jmp);
    for (int i = 0; i < gnt_dly; i++) begin
      noise(1'b0, 1'b1, 1'b1);
      checks++;
      if ({imem_req_o, imem_addr_o, instr_valid_o, misalign_o} !== {1'b1, exp_pc, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL fetch_stall: req=%0b addr=%h vld=%0b mis=%0b expected req=1 addr=%h vld=0 mis=0",
                 imem_req_o, imem_addr_o, instr_valid_o, misalign_o, exp_pc);
      end
      tick();
    end
    noise(1'b0, 1'b0, 1'b1);
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b1;
    checks++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, exp_pc}) begin
      errors++;
      $display("FAIL fetch_gnt: req=%0b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, exp_pc);
    end
    tick();
    for (int i = 0; i <= rv_dly; i++) begin
      noise(1'b1, 1'b0, 1'b1);
      if (i == rv_dly) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
      end
      checks++;
      if ({imem_req_o, instr_valid_o} !== 2'b00) begin
        errors++;
        $display("FAIL wait_phase: req=%0b vld=%0b expected 0 0", imem_req_o, instr_valid_o);
      end
      tick();
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      noise(1'b1, 1'b1, 1'b0);
      if (i == rdy_dly) begin
        instr_ready_i = 1'b1;
        jump_i        = j;
        pc_seq_i      = seq;
        pc_jump_i     = jmp;
      end
      checks++;
      if ({instr_valid_o, imem_req_o, instr_o, pc_o, pc_add4_o} !==
          {1'b1, 1'b0, data, exp_pc, exp_pc + 32'd4}) begin
        errors++;
        $display("FAIL hold: vld=%0b req=%0b instr=%h pc=%h pc4=%h expected vld=1 req=0 instr=%h pc=%h pc4=%h",
                 instr_valid_o, imem_req_o, instr_o, pc_o, pc_add4_o, data, exp_pc, exp_pc + 32'd4);
      end
      tick();
    end
    model_retire(j, seq, jmp);
    noise(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    noise(1'b1, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    noise(1'b0, 1'b0, 1'b0);
    exp_pc   = RESET_PC;
    exp_halt = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({imem_req_o, imem_addr_o, pc_o, instr_valid_o, instr_o, misalign_o, pc_add4_o} !==
        {1'b1, RESET_PC, RESET_PC, 1'b0, NOP, 1'b0, RESET_PC + 32'd4}) begin
      errors++;
      $display("FAIL reset_state: req=%0b addr=%h pc=%h vld=%0b instr=%h mis=%0b pc4=%h",
               imem_req_o, imem_addr_o, pc_o, instr_valid_o, instr_o, misalign_o, pc_add4_o);
    end
  endtask

  task automatic test_basic();
    run_txn(0, 0, 32'h0050_0093, 0, 1'b0, 32'h4, 32'h0);
    checks++;
    if ({pc_o, imem_addr_o, imem_req_o} !== {32'h4, 32'h4, 1'b1}) begin
      errors++;
      $display("FAIL seq_next: pc=%h addr=%h req=%0b expected 4 4 1", pc_o, imem_addr_o, imem_req_o);
    end
    run_txn(0, 0, 32'h0000_0033, 0, 1'b1, 32'h8, 32'h100);
    checks++;
    if (pc_o !== 32'h100) begin
      errors++;
      $display("FAIL jump_next: pc=%h expected 00000100", pc_o);
    end
  endtask

  task automatic test_stall();
    run_txn(3, 2, 32'hDEAD_BEEF, 5, 1'b0, 32'h104, 32'h0);
    checks++;
    if (pc_o !== 32'h104) begin
      errors++;
      $display("FAIL stall_next: pc=%h expected 00000104", pc_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 30; n++) begin
      logic [31:0] seq, jmp;
      seq = $urandom;
      jmp = $urandom;
`ifdef IF_MISALIGN_TRAP_EN
      seq = seq & ~32'h3;
      jmp = jmp & ~32'h3;
`endif
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
              $urandom_range(0, 4), 1'($urandom_range(0, 1)), seq, jmp);
    end
    checks++;
    if (pc_o !== exp_pc) begin
      errors++;
      $display("FAIL random_final_pc: pc=%h expected %h", pc_o, exp_pc);
    end
  endtask

  task automatic test_wrap();
    run_txn(1, 0, 32'h1111_1111, 1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    checks++;
    if ({imem_addr_o, pc_add4_o} !== {32'hFFFF_FFFC, 32'h0000_0000}) begin
      errors++;
      $display("FAIL pc_wrap: addr=%h pc4=%h expected fffffffc 00000000", imem_addr_o, pc_add4_o);
    end
    run_txn(0, 1, 32'h2222_2222, 0, 1'b0, 32'h0, 32'h40);
  endtask

  task automatic test_reset_wait();
    run_txn(0, 0, 32'h3333_3333, 0, 1'b1, 32'h0, 32'h40);
    imem_gnt_i = 1'b1;
    tick();
    noise(1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    noise(1'b0, 1'b0, 1'b0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_BAD0;
    exp_pc = RESET_PC;
    checks++;
    if ({imem_req_o, instr_valid_o, pc_o} !== {1'b1, 1'b0, RESET_PC}) begin
      errors++;
      $display("FAIL rst_in_wait: req=%0b vld=%0b pc=%h expected 1 0 %h", imem_req_o, instr_valid_o, pc_o, RESET_PC);
    end
    tick();
    noise(1'b0, 1'b0, 1'b0);
    checks++;
    if ({imem_req_o, instr_valid_o, instr_o, imem_addr_o} !== {1'b1, 1'b0, NOP, RESET_PC}) begin
      errors++;
      $display("FAIL late_rvalid: req=%0b vld=%0b instr=%h addr=%h expected 1 0 %h %h",
               imem_req_o, instr_valid_o, instr_o, imem_addr_o, NOP, RESET_PC);
    end
  endtask

  task automatic test_reset_hold();
    run_txn(0, 0, 32'h4444_4444, 0, 1'b0, 32'h80, 32'h0);
    imem_gnt_i = 1'b1;
    tick();
    noise(1'b0, 1'b0, 1'b0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h5555_5555;
    tick();
    rst           = 1'b1;
    instr_ready_i = 1'b1;
    jump_i        = 1'b1;
    pc_jump_i     = 32'h200;
    imem_rvalid_i = 1'b0;
    tick();
    rst = 1'b0;
    noise(1'b0, 1'b0, 1'b0);
    exp_pc = RESET_PC;
    checks++;
    if ({imem_req_o, instr_valid_o, instr_o, pc_o} !== {1'b1, 1'b0, NOP, RESET_PC}) begin
      errors++;
      $display("FAIL rst_priority: req=%0b vld=%0b instr=%h pc=%h expected 1 0 %h %h",
               imem_req_o, instr_valid_o, instr_o, pc_o, NOP, RESET_PC);
    end
  endtask

  task automatic test_misalign();
    run_txn(0, 0, 32'h6666_6666, 0, 1'b1, 32'h0, 32'h0F0);
    run_txn(0, 1, 32'h7777_7777, 1, 1'b1, 32'h0F4, 32'h102);
`ifdef IF_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      noise(1'b1, 1'b1, 1'b1);
      checks++;
      if ({misalign_o, imem_req_o, instr_valid_o, pc_o} !== {1'b1, 1'b0, 1'b0, 32'h0F0}) begin
        errors++;
        $display("FAIL halt: mis=%0b req=%0b vld=%0b pc=%h expected 1 0 0 000000f0",
                 misalign_o, imem_req_o, instr_valid_o, pc_o);
      end
      tick();
    end
    do_reset();
    checks++;
    if ({misalign_o, imem_req_o, pc_o} !== {1'b0, 1'b1, RESET_PC}) begin
      errors++;
      $display("FAIL halt_recover: mis=%0b req=%0b pc=%h expected 0 1 %h", misalign_o, imem_req_o, pc_o, RESET_PC);
    end
`else
    checks++;
    if ({pc_o, misalign_o, imem_req_o} !== {32'h100, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL misalign_clear: pc=%h mis=%0b req=%0b expected 00000100 0 1", pc_o, misalign_o, imem_req_o);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    exp_pc = RESET_PC;
    exp_halt = 1'b0;
    noise(1'b0, 1'b0, 1'b0);
    tick();
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_reset_wait();
    test_reset_hold();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
